// File: rtl/frame_sequencer_pkg.sv
// frame_sequencer_pkg: shared widths, FSM state encodings and the latched feature record.
package frame_sequencer_pkg;
    localparam int LOC_SIZE        = 16;
    localparam int LBL_WIDTH       = 8;
    localparam int PIXEL_SIZE      = 8;
    localparam int FRAME_WIDTH_DEF = 640;
    localparam logic [1:0] SEQ_IDLE    = 2'd0;
    localparam logic [1:0] SEQ_STREAM  = 2'd1;
    localparam logic [1:0] SEQ_FLUSH   = 2'd2;
    localparam logic [1:0] SEQ_READOUT = 2'd3;
    typedef struct packed {
        logic [LBL_WIDTH-1:0] id;
        logic [LOC_SIZE-1:0]  area;
        logic [LOC_SIZE-1:0]  x;
        logic [LOC_SIZE-1:0]  y;
    } stat_rec_t;
endpackage

// File: rtl/frame_sequencer_if.sv
// frame_sequencer_if: pixel stream in and feature record out, both valid/ready handshakes.
interface frame_sequencer_if;
    import frame_sequencer_pkg::*;
    logic [PIXEL_SIZE-1:0] pix_data;
    logic                  pix_valid;
    logic                  pix_ready;
    logic                  stat_valid;
    logic                  stat_ready;
    logic [LBL_WIDTH-1:0]  stat_id;
    logic [LOC_SIZE-1:0]   stat_area;
    logic [LOC_SIZE-1:0]   stat_x;
    logic [LOC_SIZE-1:0]   stat_y;
    modport master (
        input  pix_data, pix_valid, stat_ready,
        output pix_ready, stat_valid, stat_id, stat_area, stat_x, stat_y
    );
    modport slave (
        output pix_data, pix_valid, stat_ready,
        input  pix_ready, stat_valid, stat_id, stat_area, stat_x, stat_y
    );
endinterface

// File: rtl/frame_sequencer_raster_counter.sv
// raster_counter: raster-order x/y position with a flag on the final pixel of the frame.
module raster_counter import frame_sequencer_pkg::*; #(
    parameter int WIDTH  = FRAME_WIDTH_DEF,
    parameter int HEIGHT = 480
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                step,
    output logic [LOC_SIZE-1:0] x,
    output logic [LOC_SIZE-1:0] y,
    output logic                last
);
    localparam logic [LOC_SIZE-1:0] X_MAX = LOC_SIZE'(WIDTH - 1);
    localparam logic [LOC_SIZE-1:0] Y_MAX = LOC_SIZE'(HEIGHT - 1);

    assign last = (x == X_MAX) && (y == Y_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (step) begin
            x <= (x == X_MAX) ? '0 : x + 1'b1;
            y <= (x != X_MAX) ? y : (y == Y_MAX) ? '0 : y + 1'b1;
        end
    end
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: streams one frame into the pipeline, flushes its latency,
// then reads every label's features out as one record per handshake.
module frame_sequencer import frame_sequencer_pkg::*; #(
    parameter int FRAME_WIDTH  = FRAME_WIDTH_DEF,
    parameter int FRAME_HEIGHT = 480,
    parameter int FLUSH_CYCLES = 2 * FRAME_WIDTH + 16,
    parameter int READ_WAIT    = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    frame_sequencer_if.master     bus,
    output logic                  top_en,
    output logic [LOC_SIZE-1:0]   top_x,
    output logic [LOC_SIZE-1:0]   top_y,
    output logic [PIXEL_SIZE-1:0] top_data,
    output logic [LBL_WIDTH-1:0]  top_obj_id,
    input  logic [LBL_WIDTH-1:0]  num_labels,
    input  logic [LOC_SIZE-1:0]   obj_area,
    input  logic [LOC_SIZE-1:0]   obj_x,
    input  logic [LOC_SIZE-1:0]   obj_y,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int FCW = $clog2(FLUSH_CYCLES + 1);
    localparam int WCW = $clog2(READ_WAIT + 1);

    logic [1:0]           state;
    logic [FCW-1:0]       fcnt;
    logic [WCW-1:0]       wcnt;
    logic [LBL_WIDTH-1:0] n;
    logic [LOC_SIZE-1:0]  cx, cy;
    logic                 last, accept;
    stat_rec_t            rec;

    assign accept        = (state == SEQ_STREAM) && bus.pix_valid;
    assign bus.pix_ready = state == SEQ_STREAM;
    assign busy          = state != SEQ_IDLE;
    assign bus.stat_id   = rec.id;
    assign bus.stat_area = rec.area;
    assign bus.stat_x    = rec.x;
    assign bus.stat_y    = rec.y;

    raster_counter #(.WIDTH(FRAME_WIDTH), .HEIGHT(FRAME_HEIGHT)) u_raster (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   ((state == SEQ_IDLE) && start),
        .step    (accept),
        .x       (cx),
        .y       (cy),
        .last    (last)
    );

    // top_obj_id doubles as the readout label counter; it stays frozen between frames.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= SEQ_IDLE;
            fcnt           <= '0;
            wcnt           <= '0;
            n              <= '0;
            rec            <= '0;
            bus.stat_valid <= 1'b0;
            top_en         <= 1'b0;
            top_x          <= '0;
            top_y          <= '0;
            top_data       <= '0;
            top_obj_id     <= '0;
            frame_done     <= 1'b0;
        end else begin
            top_en     <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                SEQ_IDLE: if (start) state <= SEQ_STREAM;
                SEQ_STREAM: if (accept) begin
                    top_en   <= 1'b1;
                    top_data <= bus.pix_data;
                    top_x    <= cx;
                    top_y    <= cy;
                    if (last) begin
                        state <= SEQ_FLUSH;
                        fcnt  <= '0;
                    end
                end
                SEQ_FLUSH: begin
                    top_en   <= 1'b1;
                    top_data <= '0;
                    fcnt     <= fcnt + 1'b1;
                    if (fcnt == FCW'(FLUSH_CYCLES - 1)) begin
                        state      <= SEQ_READOUT;
                        n          <= num_labels;
                        top_obj_id <= LBL_WIDTH'(1);
                        wcnt       <= '0;
                    end
                end
                default: if (n == '0) begin
                    frame_done <= 1'b1;
                    state      <= SEQ_IDLE;
                end else if (!bus.stat_valid) begin
                    wcnt <= (wcnt == WCW'(READ_WAIT - 1)) ? '0 : wcnt + 1'b1;
                    if (wcnt == WCW'(READ_WAIT - 1)) begin
                        rec            <= {top_obj_id, obj_area, obj_x, obj_y};
                        bus.stat_valid <= 1'b1;
                    end
                end else if (bus.stat_ready) begin
                    bus.stat_valid <= 1'b0;
                    if (top_obj_id == n) begin
                        frame_done <= 1'b1;
                        state      <= SEQ_IDLE;
                    end else begin
                        top_obj_id <= top_obj_id + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: scenario tasks with scoreboard queues for pixel beats and feature records.
module tb_frame_sequencer;
    import frame_sequencer_pkg::*;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int F  = 12;
    localparam int RW = 2;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  start = 1'b0;
    logic                  top_en;
    logic [LOC_SIZE-1:0]   top_x, top_y;
    logic [PIXEL_SIZE-1:0] top_data;
    logic [LBL_WIDTH-1:0]  top_obj_id;
    logic [LBL_WIDTH-1:0]  num_labels = '0;
    logic [LOC_SIZE-1:0]   obj_area, obj_x, obj_y;
    logic                  busy, frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [LOC_SIZE-1:0]   x;
        logic [LOC_SIZE-1:0]   y;
        logic [PIXEL_SIZE-1:0] d;
    } beat_t;
    typedef struct {
        logic [LBL_WIDTH-1:0] id;
        logic [LOC_SIZE-1:0]  a;
        logic [LOC_SIZE-1:0]  x;
        logic [LOC_SIZE-1:0]  y;
    } rec_t;
    beat_t bq[$];
    rec_t  rq[$];

    frame_sequencer_if bus();

    frame_sequencer #(
        .FRAME_WIDTH (W),
        .FRAME_HEIGHT(H),
        .FLUSH_CYCLES(F),
        .READ_WAIT   (RW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .bus       (bus.master),
        .top_en    (top_en),
        .top_x     (top_x),
        .top_y     (top_y),
        .top_data  (top_data),
        .top_obj_id(top_obj_id),
        .num_labels(num_labels),
        .obj_area  (obj_area),
        .obj_x     (obj_x),
        .obj_y     (obj_y),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Stand-in for the pipeline's feature tables, keyed by the selected label.
    assign obj_area = LOC_SIZE'(top_obj_id) * LOC_SIZE'(100) + LOC_SIZE'(5);
    assign obj_x    = LOC_SIZE'(top_obj_id) * LOC_SIZE'(3) + LOC_SIZE'(1);
    assign obj_y    = LOC_SIZE'(top_obj_id) * LOC_SIZE'(5) + LOC_SIZE'(2);

    function automatic logic [PIXEL_SIZE-1:0] pd(int i);
        return PIXEL_SIZE'(i * 7 + 3);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drive_beats(int first, int count);
        for (int i = first; i < first + count; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data  = pd(i);
            tick();
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic push_records(int n);
        for (int k = 1; k <= n; k++)
            rq.push_back('{id: LBL_WIDTH'(k), a: LOC_SIZE'(k * 100 + 5),
                           x: LOC_SIZE'(k * 3 + 1), y: LOC_SIZE'(k * 5 + 2)});
    endtask

    task automatic drain;
        bus.stat_ready = 1'b1;
        for (int c = 0; c < 300 && busy; c++) tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_timeout: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset;
        bus.pix_valid  = 1'b0;
        bus.pix_data   = '0;
        bus.stat_ready = 1'b0;
        reset_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({top_en, top_x, top_y, top_data, top_obj_id, frame_done, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_top: en=%b x=%0d y=%0d d=%0d id=%0d done=%b busy=%b, want all 0",
                     top_en, top_x, top_y, top_data, top_obj_id, frame_done, busy);
        end
        n_checks++;
        if ({bus.stat_valid, bus.stat_id, bus.stat_area, bus.stat_x, bus.stat_y, bus.pix_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_stat: v=%b id=%0d a=%0d x=%0d y=%0d rdy=%b, want all 0",
                     bus.stat_valid, bus.stat_id, bus.stat_area, bus.stat_x, bus.stat_y, bus.pix_ready);
        end
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || bus.pix_ready !== 1'b0 || top_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b rdy=%b en=%b, want 0 0 0", busy, bus.pix_ready, top_en);
        end
    endtask

    task automatic test_full_stream;
        beat_t b;
        num_labels     = 3;
        bus.stat_ready = 1'b1;
        start_frame();
        n_checks++;
        if (bus.pix_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_ready: rdy=%b busy=%b, want 1 1", bus.pix_ready, busy);
        end
        for (int i = 0; i < W * H; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data  = pd(i);
            bq.push_back('{x: LOC_SIZE'(i % W), y: LOC_SIZE'(i / W), d: pd(i)});
            tick();
            b = bq.pop_front();
            n_checks++;
            if (top_en !== 1'b1 || top_x !== b.x || top_y !== b.y || top_data !== b.d) begin
                n_fail++;
                $display("FAIL stream_beat%0d: en=%b x=%0d y=%0d d=%0d, want en=1 x=%0d y=%0d d=%0d",
                         i, top_en, top_x, top_y, top_data, b.x, b.y, b.d);
            end
        end
        bus.pix_valid = 1'b0;
        for (int j = 0; j < F; j++) begin
            tick();
            n_checks++;
            if (top_en !== 1'b1 || top_data !== '0 || top_x !== W - 1 || top_y !== H - 1) begin
                n_fail++;
                $display("FAIL flush%0d: en=%b d=%0d x=%0d y=%0d, want en=1 d=0 x=%0d y=%0d",
                         j, top_en, top_data, top_x, top_y, W - 1, H - 1);
            end
        end
        tick();
        n_checks++;
        if (top_en !== 1'b0 || bus.pix_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_end: en=%b rdy=%b, want 0 0", top_en, bus.pix_ready);
        end
    endtask

    task automatic test_readout;
        rec_t r;
        int   last_c = -1;
        int   fd     = 0;
        int   recs   = 0;
        push_records(3);
        for (int c = 0; c < 30; c++) begin
            tick();
            start = 1'b0;
            if (frame_done === 1'b1) fd++;
            if (bus.stat_valid === 1'b1) begin
                recs++;
                n_checks++;
                if (rq.size() == 0) begin
                    n_fail++;
                    $display("FAIL readout_extra: got id=%0d, want no record", bus.stat_id);
                end else begin
                    r = rq.pop_front();
                    if (bus.stat_id !== r.id || bus.stat_area !== r.a || bus.stat_x !== r.x || bus.stat_y !== r.y) begin
                        n_fail++;
                        $display("FAIL readout_rec: id=%0d a=%0d x=%0d y=%0d, want id=%0d a=%0d x=%0d y=%0d",
                                 bus.stat_id, bus.stat_area, bus.stat_x, bus.stat_y, r.id, r.a, r.x, r.y);
                    end
                end
                if (last_c >= 0) begin
                    n_checks++;
                    if (c - last_c != RW + 1) begin
                        n_fail++;
                        $display("FAIL readout_spacing: %0d cycles, want %0d", c - last_c, RW + 1);
                    end
                end
                last_c = c;
                if (bus.stat_id == 3) start = 1'b1;
            end
        end
        n_checks++;
        if (fd != 1 || recs != 3 || rq.size() != 0) begin
            n_fail++;
            $display("FAIL readout_count: done=%0d recs=%0d left=%0d, want 1 3 0", fd, recs, rq.size());
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_at_last_handshake: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_stall;
        beat_t b;
        num_labels = 1;
        start_frame();
        for (int i = 0; i < W * H; i++) begin
            if (i == W + 3) begin
                bus.pix_valid = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    n_checks++;
                    if (top_en !== 1'b0 || bus.pix_ready !== 1'b1) begin
                        n_fail++;
                        $display("FAIL stall%0d: en=%b rdy=%b, want en=0 rdy=1", s, top_en, bus.pix_ready);
                    end
                end
            end
            bus.pix_valid = 1'b1;
            bus.pix_data  = pd(i);
            bq.push_back('{x: LOC_SIZE'(i % W), y: LOC_SIZE'(i / W), d: pd(i)});
            tick();
            b = bq.pop_front();
            n_checks++;
            if (top_en !== 1'b1 || top_x !== b.x || top_y !== b.y || top_data !== b.d) begin
                n_fail++;
                $display("FAIL stall_beat%0d: en=%b x=%0d y=%0d d=%0d, want en=1 x=%0d y=%0d d=%0d",
                         i, top_en, top_x, top_y, top_data, b.x, b.y, b.d);
            end
        end
        bus.pix_valid = 1'b0;
        drain();
    endtask

    task automatic test_backpressure;
        rec_t r;
        int   hold = 0;
        int   fd   = 0;
        logic prev = 1'b0;
        num_labels     = 3;
        bus.stat_ready = 1'b1;
        start_frame();
        drive_beats(0, W * H);
        push_records(3);
        for (int c = 0; c < 80; c++) begin
            tick();
            if (frame_done === 1'b1) fd++;
            if (bus.stat_valid === 1'b1 && !prev) begin
                n_checks++;
                if (rq.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra: got id=%0d, want no record", bus.stat_id);
                end else begin
                    r = rq.pop_front();
                    if (bus.stat_id !== r.id || bus.stat_area !== r.a || bus.stat_x !== r.x || bus.stat_y !== r.y) begin
                        n_fail++;
                        $display("FAIL bp_rec: id=%0d a=%0d x=%0d y=%0d, want id=%0d a=%0d x=%0d y=%0d",
                                 bus.stat_id, bus.stat_area, bus.stat_x, bus.stat_y, r.id, r.a, r.x, r.y);
                    end
                end
            end
            prev = bus.stat_valid;
            if (hold > 0 && hold < 10) begin
                n_checks++;
                if (bus.stat_valid !== 1'b1 || bus.stat_id !== 2 || bus.stat_area !== 205) begin
                    n_fail++;
                    $display("FAIL bp_hold%0d: v=%b id=%0d a=%0d, want v=1 id=2 a=205",
                             hold, bus.stat_valid, bus.stat_id, bus.stat_area);
                end
                hold++;
                bus.stat_ready = 1'b0;
            end else if (hold == 0 && bus.stat_valid === 1'b1 && bus.stat_id == 2) begin
                hold = 1;
                bus.stat_ready = 1'b0;
            end else begin
                bus.stat_ready = 1'b1;
            end
        end
        n_checks++;
        if (fd != 1 || rq.size() != 0 || hold != 10 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end: done=%0d left=%0d hold=%0d busy=%b, want 1 0 10 0", fd, rq.size(), hold, busy);
        end
    endtask

    task automatic test_empty;
        int en = 0, last_en = -1, fds = 0, fd_c = -1, sv = 0;
        num_labels = 0;
        start_frame();
        drive_beats(0, W * H);
        for (int c = 0; c < 30; c++) begin
            tick();
            if (top_en === 1'b1) begin
                en++;
                last_en = c;
            end
            if (frame_done === 1'b1) begin
                fds++;
                fd_c = c;
            end
            if (bus.stat_valid === 1'b1) sv++;
        end
        n_checks++;
        if (en != F || sv != 0) begin
            n_fail++;
            $display("FAIL empty_flush: en_cycles=%0d stat_valid_cycles=%0d, want %0d 0", en, sv, F);
        end
        n_checks++;
        if (fds != 1 || fd_c != last_en + 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_done: pulses=%0d at=%0d busy=%b, want 1 at %0d busy=0", fds, fd_c, busy, last_en + 1);
        end
    endtask

    task automatic test_reset_ignore;
        num_labels = 2;
        start_frame();
        drive_beats(0, 10);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || bus.pix_ready !== 1'b1 || top_en !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_state: busy=%b rdy=%b en=%b, want 1 1 0", busy, bus.pix_ready, top_en);
        end
        bus.pix_valid = 1'b1;
        bus.pix_data  = pd(10);
        tick();
        bus.pix_valid = 1'b0;
        n_checks++;
        if (top_en !== 1'b1 || top_x !== 2 || top_y !== 1 || top_data !== pd(10)) begin
            n_fail++;
            $display("FAIL ignore_coord: en=%b x=%0d y=%0d d=%0d, want en=1 x=2 y=1 d=%0d",
                     top_en, top_x, top_y, top_data, pd(10));
        end
        drive_beats(11, 6);
        reset_n = 1'b0;
        #2;
        n_checks++;
        if ({top_en, top_x, top_y, top_data, top_obj_id, frame_done, busy, bus.pix_ready, bus.stat_valid} !== '0) begin
            n_fail++;
            $display("FAIL midframe_reset: en=%b x=%0d y=%0d d=%0d id=%0d done=%b busy=%b rdy=%b v=%b, want all 0",
                     top_en, top_x, top_y, top_data, top_obj_id, frame_done, busy, bus.pix_ready, bus.stat_valid);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%b done=%b, want 0 0", busy, frame_done);
        end
        start_frame();
        drive_beats(0, 1);
        n_checks++;
        if (top_en !== 1'b1 || top_x !== 0 || top_y !== 0) begin
            n_fail++;
            $display("FAIL restart_origin: en=%b x=%0d y=%0d, want 1 0 0", top_en, top_x, top_y);
        end
        drive_beats(1, W * H - 1);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_stream();
        test_readout();
        test_stall();
        test_backpressure();
        test_empty();
        test_reset_ignore();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
